accumulator_controller: RTL

- Sequential front/back end for the 8-bit adder_subtractor datapath.
- Accepts LOAD/ADD/SUB/CLEAR commands over a valid/ready handshake and drives the adder's operand, carry and enable inputs.
- Captures the adder's sum and carry into an accumulator register, so the adder's result feeds the next operation.
- Reports carry, signed overflow, a completion pulse and a count of completed operations.

---
 rtl/accumulator_controller.sv | 83 ++++++++
 1 files changed

// File: rtl/accumulator_controller.sv
// accumulator_controller: valid/ready command front end and accumulator back end for the adder_subtractor datapath
module accumulator_controller #(
    parameter int WIDTH   = 8,
    parameter int COUNT_W = 8
) (
    input  logic               in_clk,
    input  logic               in_rst_n,
    input  logic               in_valid,
    output logic               ou_ready,
    input  logic [1:0]         in_op,
    input  logic [WIDTH-1:0]   in_data,
    output logic [WIDTH-1:0]   ou_add_a,
    output logic [WIDTH-1:0]   ou_add_b,
    output logic               ou_add_c,
    output logic               ou_add_en,
    input  logic [WIDTH-1:0]   in_add_s,
    input  logic               in_add_c,
    output logic [WIDTH-1:0]   ou_acc,
    output logic               ou_carry,
    output logic               ou_ovf,
    output logic               ou_done,
    output logic [COUNT_W-1:0] ou_count
);
    typedef enum logic {IDLE, ISSUE} state_t;
    state_t             r_state;
    logic [WIDTH-1:0]   r_acc;
    logic [WIDTH-1:0]   r_operand;
    logic               r_sub;
    logic               r_carry;
    logic               r_ovf;
    logic               r_done;
    logic [COUNT_W-1:0] r_count;
    logic [WIDTH-1:0]   w_beff;
    logic               w_ovf;
    logic               w_direct;
    assign w_beff    = r_sub ? ~r_operand : r_operand;
    assign w_ovf     = (r_acc[WIDTH-1] == w_beff[WIDTH-1]) && (in_add_s[WIDTH-1] != r_acc[WIDTH-1]);
    assign w_direct  = (in_op == 2'b00) || (in_op == 2'b11);
    assign ou_ready  = (r_state == IDLE);
    assign ou_add_a  = r_acc;
    assign ou_add_b  = r_operand;
    // r_sub is only ever set for the duration of a SUB's ISSUE cycle
    assign ou_add_c  = r_sub;
    assign ou_add_en = r_sub;
    assign ou_acc    = r_acc;
    assign ou_carry  = r_carry;
    assign ou_ovf    = r_ovf;
    assign ou_done   = r_done;
    assign ou_count  = r_count;
    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            r_state   <= IDLE;
            r_acc     <= '0;
            r_operand <= '0;
            r_sub     <= 1'b0;
            r_carry   <= 1'b0;
            r_ovf     <= 1'b0;
            r_done    <= 1'b0;
            r_count   <= '0;
        end else begin
            r_done <= 1'b0;
            if (r_state == ISSUE) begin
                r_acc   <= in_add_s;
                r_carry <= in_add_c;
                r_ovf   <= w_ovf;
                r_done  <= 1'b1;
                r_count <= r_count + 1'b1;
                r_sub   <= 1'b0;
                r_state <= IDLE;
            end else if (in_valid && w_direct) begin
                r_acc   <= in_op[0] ? '0 : in_data;
                r_carry <= 1'b0;
                r_ovf   <= 1'b0;
                r_done  <= 1'b1;
                r_count <= r_count + 1'b1;
            end else if (in_valid) begin
                r_operand <= in_data;
                r_sub     <= in_op[1];
                r_state   <= ISSUE;
            end
        end
    end
endmodule
